// File: rtl/fetch_unit.sv
// Instruction-fetch stage: boots the PC from a two-word reset vector, then assembles short
// (one word) and long (word + immediate) instructions into a registered IF/ID output.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned VEC_ADDR = 0,
  parameter int unsigned LONG_BIT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic [WORD_W-1:0] mem_data_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] imm_o,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic [ADDR_W-1:0] pc_next_o
);

  typedef enum logic [1:0] {StVec0, StVec1, StFetch, StFetchImm} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [WORD_W-1:0]   lat_q, lat_d;
  logic [ADDR_W-1:0]   lat_pc_q, lat_pc_d;
  logic [WORD_W-1:0]   instr_q, instr_d;
  logic [WORD_W-1:0]   imm_q, imm_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]   pc_next_q, pc_next_d;
  logic                valid_q, valid_d;

  logic [ADDR_W-1:0]   pc_inc;
  logic [2*WORD_W-1:0] vec_word;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign vec_word = {mem_data_i, lat_q};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lat_d      = lat_q;
    lat_pc_d   = lat_pc_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    instr_pc_d = instr_pc_q;
    pc_next_d  = pc_next_q;
    valid_d    = 1'b0;
    mem_rd_o   = 1'b1;
    mem_addr_o = pc_q;

    unique case (state_q)
      StVec0: begin
        mem_addr_o = ADDR_W'(VEC_ADDR);
        lat_d      = mem_data_i;
        state_d    = StVec1;
      end
      StVec1: begin
        mem_addr_o = ADDR_W'(VEC_ADDR + 1);
        pc_d       = ADDR_W'(vec_word);
        state_d    = StFetch;
      end
      StFetch, StFetchImm: begin
        if (redirect_i) begin
          // Any half-assembled long instruction and this cycle's word are dropped.
          pc_d    = redirect_pc_i;
          state_d = StFetch;
        end else if (stall_i) begin
          mem_rd_o = 1'b0;
          valid_d  = valid_q;
        end else if (state_q == StFetch && mem_data_i[LONG_BIT]) begin
          lat_d    = mem_data_i;
          lat_pc_d = pc_q;
          pc_d     = pc_inc;
          state_d  = StFetchImm;
        end else if (state_q == StFetch) begin
          instr_d    = mem_data_i;
          imm_d      = '0;
          instr_pc_d = pc_q;
          pc_next_d  = pc_inc;
          valid_d    = 1'b1;
          pc_d       = pc_inc;
        end else begin
          instr_d    = lat_q;
          imm_d      = mem_data_i;
          instr_pc_d = lat_pc_q;
          pc_next_d  = pc_inc;
          valid_d    = 1'b1;
          pc_d       = pc_inc;
          state_d    = StFetch;
        end
      end
      default: state_d = StVec0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StVec0;
      pc_q       <= '0;
      lat_q      <= '0;
      lat_pc_q   <= '0;
      instr_q    <= '0;
      imm_q      <= '0;
      instr_pc_q <= '0;
      pc_next_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      lat_q      <= lat_d;
      lat_pc_q   <= lat_pc_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      instr_pc_q <= instr_pc_d;
      pc_next_q  <= pc_next_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o       = instr_q;
  assign imm_o         = imm_q;
  assign instr_pc_o    = instr_pc_q;
  assign pc_next_o     = pc_next_q;
  assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed boot/stall/redirect/reset/wrap cases, then random traffic
// checked against an instruction-level model of the fetched stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] mem_data;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [15:0] instr;
  logic [15:0] imm;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] pc_next;

  always #5 clk = ~clk;

  // 256-word memory image, aliased over the whole address space.
  logic [15:0] mem [0:255];
  assign mem_data = mem[mem_addr[7:0]];

  fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .mem_data_i    (mem_data),
    .mem_addr_o    (mem_addr),
    .mem_rd_o      (mem_rd),
    .instr_o       (instr),
    .imm_o         (imm),
    .instr_valid_o (instr_valid),
    .instr_pc_o    (instr_pc),
    .pc_next_o     (pc_next)
  );

  int checks   = 0;
  int failures = 0;

  // Model: vector words seen so far, next instruction address, words of it already consumed,
  // and the IF/ID contents the bench expects.
  int          boot;
  int          k;
  logic [31:0] exp_pc;
  logic [15:0] e_instr;
  logic [15:0] e_imm;
  logic [31:0] e_ipc;
  logic [31:0] e_pnext;
  logic        e_valid;

  function automatic logic [15:0] rd_mem(input logic [31:0] a);
    return mem[a[7:0]];
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("instr", 32'(instr), 32'(e_instr));
    check_val("imm", 32'(imm), 32'(e_imm));
    check_val("instr_pc", instr_pc, e_ipc);
    check_val("pc_next", pc_next, e_pnext);
    check_val("instr_valid", 32'(instr_valid), 32'(e_valid));
  endtask

  task automatic model_reset();
    boot    = 0;
    k       = 0;
    exp_pc  = '0;
    e_instr = '0;
    e_imm   = '0;
    e_ipc   = '0;
    e_pnext = '0;
    e_valid = 1'b0;
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    logic [31:0] exp_addr;
    logic        exp_rd;
    logic [15:0] first;
    int          len;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    if (boot < 2) begin
      exp_addr = 32'(boot);
      exp_rd   = 1'b1;
    end else begin
      exp_addr = exp_pc + 32'(k);
      exp_rd   = !(st && !rd);
    end
    check_val("mem_addr", mem_addr, exp_addr);
    check_val("mem_rd", 32'(mem_rd), 32'(exp_rd));
    @(posedge clk);
    #1;
    if (boot < 2) begin
      if (boot == 1) exp_pc = {mem[1], mem[0]};
      boot++;
    end else if (rd) begin
      exp_pc  = rpc;
      k       = 0;
      e_valid = 1'b0;
    end else if (!st) begin
      first = rd_mem(exp_pc);
      len   = first[15] ? 2 : 1;
      k++;
      if (k == len) begin
        e_instr = first;
        e_imm   = (len == 2) ? rd_mem(exp_pc + 32'd1) : 16'h0000;
        e_ipc   = exp_pc;
        e_pnext = exp_pc + 32'(len);
        e_valid = 1'b1;
        exp_pc  = exp_pc + 32'(len);
        k       = 0;
      end else begin
        e_valid = 1'b0;
      end
    end
    check_outputs();
    @(negedge clk);
    stall    = 1'b0;
    redirect = 1'b0;
  endtask

  // Reset asserted between edges must clear the outputs without waiting for a clock.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0]    = 16'h0020;
    mem[1]    = 16'h0000;
    mem[8'h20] = 16'h1234;
    mem[8'h21] = 16'h0456;
    mem[8'h22] = 16'h8A00;
    mem[8'h23] = 16'hBEEF;
    mem[8'h24] = 16'h0111;
    mem[8'h25] = 16'h9000;
    mem[8'h26] = 16'h5555;
    mem[8'h40] = 16'h0777;
    mem[8'hFF] = 16'h8123;

    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Boot from the vector, then a short pair and a long instruction.
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check_val("t1_first_pc", instr_pc, 32'h20);
    check_val("t2_instr0", 32'(instr), 32'h1234);
    step(1'b0, 1'b0, '0);
    check_val("t2_pc_next1", pc_next, 32'h22);
    step(1'b0, 1'b0, '0);
    check_val("t3_gap", 32'(instr_valid), 32'h0);
    step(1'b0, 1'b0, '0);
    check_val("t3_imm", 32'(imm), 32'hBEEF);
    check_val("t3_pc_next", pc_next, 32'h24);

    // Stall while valid, then resume at the following address.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check_val("t4_resume_pc", instr_pc, 32'h24);

    // Redirect (with stall) while the long instruction at 0x25 is half fetched.
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h40);
    step(1'b0, 1'b0, '0);
    check_val("t5_target", 32'(instr), 32'h0777);

    // Mid-cycle reset, vector re-read before the next valid instruction.
    step(1'b0, 1'b0, '0);
    async_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check_val("t6_reboot_pc", instr_pc, 32'h20);

    // Long instruction straddling the address wrap.
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check_val("wrap_instr", 32'(instr), 32'h8123);
    check_val("wrap_pc_next", pc_next, 32'h0000_0001);

    for (int n = 0; n < 3000; n++) begin
      int          r;
      logic [31:0] tgt;
      r   = $urandom_range(0, 199);
      tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 1)))
                                        : 32'($urandom_range(0, 255));
      if (r == 0) async_reset();
      else if (r < 20) step(1'b0, 1'b1, tgt);
      else if (r < 30) step(1'b1, 1'b1, tgt);
      else if (r < 80) step(1'b1, 1'b0, tgt);
      else step(1'b0, 1'b0, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
